// File: rtl/truth_table_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_pkg
// Shared definitions for the truth-table sweeper: sweep geometry and the
// controller state type.
//   NUM_VEC : number of input vectors swept (2^4 for a 4-input circuit)
//   VEC_W   : width of a vector index
//   TABLE_W : width of a full truth table (one bit per vector)
//   state_t : controller states IDLE / RUN / DONE
// ---------------------------------------------------------------------------
package truth_table_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int TABLE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Counts how long the current input vector has been applied to the circuit
// under test. The count runs 0..DWELL-1 and wraps, and 'last' flags the final
// cycle of each dwell period, which is when the sweeper samples f.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (count -> 0)
//   clear  : force the count back to 0 (takes priority over enable)
//   enable : advance the count this cycle
//   last   : high while the count equals DWELL-1
// ---------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    // A single-cycle dwell still needs a one-bit register to stay legal;
    // with DWELL=1 the count sits at 0 and 'last' is permanently high.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last = (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Drives all 16 input vectors of a 4-input circuit under test, holds each one
// for DWELL cycles, samples the circuit output f on the last dwell cycle and
// compares the captured truth table against a golden table latched at start.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start           : request a sweep (accepted in IDLE only)
//   abort           : abandon a sweep in progress (RUN only)
//   expected[15:0]  : golden truth table, latched when start is accepted
//   a, b, c, d      : current vector to the circuit under test, a = MSB
//   f               : circuit output sampled by the sweeper
//   busy            : sweep in progress
//   done            : one-cycle pulse at sweep completion
//   pass            : captured table matched expected (valid from done)
//   table_out[15:0] : captured truth table, bit i = f for vector i
//   fail_idx[3:0]   : lowest mismatching vector index, 0 when pass
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter int NUM_VEC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [TABLE_W-1:0] expected,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    input  logic               f,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [TABLE_W-1:0] table_out,
    output logic [VEC_W-1:0]   fail_idx
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_t             state_q,    state_d;
    logic [VEC_W-1:0]   vec_q,      vec_d;
    logic [TABLE_W-1:0] exp_q,      exp_d;
    logic [TABLE_W-1:0] table_q,    table_d;
    logic [VEC_W-1:0]   fail_idx_q, fail_idx_d;
    logic               mismatch_q, mismatch_d;
    logic               pass_q,     pass_d;

    logic dwell_last;
    logic timer_clear;
    logic timer_en;
    logic sample_bad;

    // The dwell count only moves in RUN; holding it cleared elsewhere means
    // every sweep (and every restart after abort) begins at count 0.
    assign timer_en    = (state_q == RUN);
    assign timer_clear = (state_q != RUN) || abort;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .last   (dwell_last)
    );

    assign sample_bad = (f != exp_q[vec_q]);

    // Sweep sequencing. Abort takes priority over the sample taken on the
    // same cycle, so an aborted sweep never records a final sample or pulses
    // done. The pass verdict folds in the last sample because the mismatch
    // flag for vector 15 only lands on the same edge that enters DONE.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        exp_d      = exp_q;
        table_d    = table_q;
        fail_idx_d = fail_idx_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    exp_d      = expected;
                    vec_d      = '0;
                    table_d    = '0;
                    fail_idx_d = '0;
                    mismatch_d = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (dwell_last) begin
                    table_d[vec_q] = f;
                    if (sample_bad && !mismatch_q) begin
                        mismatch_d = 1'b1;
                        fail_idx_d = vec_q;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        pass_d  = !(mismatch_q || sample_bad);
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            fail_idx_q <= '0;
            mismatch_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            exp_q      <= exp_d;
            table_q    <= table_d;
            fail_idx_q <= fail_idx_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
        end
    end

    // The vector is only presented while sweeping; the circuit under test
    // sees all-zero inputs otherwise.
    assign {a, b, c, d} = (state_q == RUN) ? vec_q : '0;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign pass         = pass_q;
    assign table_out    = table_q;
    assign fail_idx     = fail_idx_q;

endmodule
